// File: rtl/psr_cond.sv
// Processor status register {C,L,F,Z,N} with masked ALU flag capture, interrupt
// shadow save/restore and a 4-bit branch condition evaluator. Optional macro: PSR_FORWARD_EN.
module psr_cond (
  input  logic       clk,
  input  logic       reset,
  input  logic       flagWe,
  input  logic [4:0] flagMask,
  input  logic       aluC,
  input  logic       aluL,
  input  logic       aluF,
  input  logic       aluZ,
  input  logic       aluN,
  input  logic       psrWe,
  input  logic [4:0] psrIn,
  input  logic       intEnter,
  input  logic       intReturn,
  input  logic [3:0] cond,
  output logic [4:0] psr,
  output logic       take,
  output logic       inIsr,
  output logic       intAck
);

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_ISR = 1'b1
  } state_e;

  localparam int C_BIT = 4;
  localparam int L_BIT = 3;
  localparam int F_BIT = 2;
  localparam int Z_BIT = 1;
  localparam int N_BIT = 0;

  state_e     state_q, state_d;
  logic [4:0] psr_q, psr_d;
  logic [4:0] shadow_q, shadow_d;
  logic       ack_q, ack_d;
  logic [4:0] alu_flags;
  logic [4:0] merged;
  logic [4:0] eval_flags;
  logic       restore;

  function automatic logic cond_true(input logic [3:0] c, input logic [4:0] f);
    logic r;
    case (c)
      4'd0:    r = f[Z_BIT];
      4'd1:    r = ~f[Z_BIT];
      4'd2:    r = f[C_BIT];
      4'd3:    r = ~f[C_BIT];
      4'd4:    r = f[L_BIT];
      4'd5:    r = ~f[L_BIT];
      4'd6:    r = f[N_BIT];
      4'd7:    r = ~f[N_BIT];
      4'd8:    r = f[F_BIT];
      4'd9:    r = ~f[F_BIT];
      4'd10:   r = ~f[L_BIT] & ~f[Z_BIT];
      4'd11:   r = f[L_BIT] | f[Z_BIT];
      4'd12:   r = ~f[N_BIT] & ~f[Z_BIT];
      4'd13:   r = f[N_BIT] | f[Z_BIT];
      4'd14:   r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign alu_flags = {aluC, aluL, aluF, aluZ, aluN};
  assign merged    = (psr_q & ~flagMask) | (alu_flags & flagMask);
  // A return outside an ISR has no shadow to restore and falls through.
  assign restore   = intReturn && (state_q == ST_ISR);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    psr_d    = psr_q;
    state_d  = state_q;
    shadow_d = shadow_q;
    ack_d    = 1'b0;

    if (restore)     psr_d = shadow_q;
    else if (psrWe)  psr_d = psrIn;
    else if (flagWe) psr_d = merged;

    case (state_q)
      ST_RUN: begin
        if (intEnter) begin
          // Saving the next-PSR keeps a flag or LPR write issued alongside the entry.
          shadow_d = psr_d;
          ack_d    = 1'b1;
          state_d  = ST_ISR;
        end
      end
      ST_ISR: begin
        if (intReturn) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

`ifdef PSR_FORWARD_EN
  assign eval_flags = psr_d;
`else
  assign eval_flags = psr_q;
`endif

  assign take   = cond_true(cond, eval_flags);
  assign psr    = psr_q;
  assign inIsr  = (state_q == ST_ISR);
  assign intAck = ack_q;

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_RUN;
      psr_q    <= 5'b0;
      shadow_q <= 5'b0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      psr_q    <= psr_d;
      shadow_q <= shadow_d;
      ack_q    <= ack_d;
    end
  end

endmodule

// File: tb/tb_psr_cond.sv
// Scoreboard bench for psr_cond: a driver pushes expected outputs from a flag-level
// reference model; a monitor pops and compares on every falling edge.
module tb_psr_cond;

`ifdef PSR_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       flagWe = 1'b0;
  logic [4:0] flagMask = 5'b0;
  logic       aluC = 1'b0, aluL = 1'b0, aluF = 1'b0, aluZ = 1'b0, aluN = 1'b0;
  logic       psrWe = 1'b0;
  logic [4:0] psrIn = 5'b0;
  logic       intEnter = 1'b0;
  logic       intReturn = 1'b0;
  logic [3:0] cond = 4'd0;
  logic [4:0] psr;
  logic       take;
  logic       inIsr;
  logic       intAck;

  psr_cond dut (
    .clk       (clk),
    .reset     (reset),
    .flagWe    (flagWe),
    .flagMask  (flagMask),
    .aluC      (aluC),
    .aluL      (aluL),
    .aluF      (aluF),
    .aluZ      (aluZ),
    .aluN      (aluN),
    .psrWe     (psrWe),
    .psrIn     (psrIn),
    .intEnter  (intEnter),
    .intReturn (intReturn),
    .cond      (cond),
    .psr       (psr),
    .take      (take),
    .inIsr     (inIsr),
    .intAck    (intAck)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       rst;
    bit       fwe;
    bit [4:0] fmask;
    bit [4:0] alu;
    bit       pwe;
    bit [4:0] pin;
    bit       ie;
    bit       ir;
    bit [3:0] cnd;
  } stim_t;

  typedef struct {
    logic [4:0] psr;
    logic       isr;
    logic       ack;
    logic       take;
  } exp_t;

  exp_t expq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  bit [4:0] m_psr = 5'b0, m_shadow = 5'b0;
  bit       m_isr = 1'b0, m_ack = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Truth value of every condition code, indexed by the code itself.
  function automatic bit model_take(input bit [3:0] c, input bit [4:0] f);
    bit fc, fl, ff, fz, fn;
    bit [15:0] tv;
    {fc, fl, ff, fz, fn} = f;
    tv = {1'b0, 1'b1, fn | fz, !fn && !fz, fl | fz, !fl && !fz, !ff, ff,
          !fn, fn, !fl, fl, !fc, fc, !fz, fz};
    return tv[c];
  endfunction

  function automatic stim_t idle(input bit [3:0] c);
    stim_t s;
    s = '{rst: 1'b0, fwe: 1'b0, fmask: 5'b0, alu: 5'b0, pwe: 1'b0, pin: 5'b0,
          ie: 1'b0, ir: 1'b0, cnd: c};
    return s;
  endfunction

  task automatic step(input stim_t s);
    bit [4:0] merged, nxt;
    bit       accept;
    exp_t     e;
    @(posedge clk);
    #1;
    reset     = s.rst;
    flagWe    = s.fwe;
    flagMask  = s.fmask;
    {aluC, aluL, aluF, aluZ, aluN} = s.alu;
    psrWe     = s.pwe;
    psrIn     = s.pin;
    intEnter  = s.ie;
    intReturn = s.ir;
    cond      = s.cnd;
    if (s.rst) begin
      m_psr = 5'b0; m_shadow = 5'b0; m_isr = 1'b0; m_ack = 1'b0;
    end
    for (int i = 0; i < 5; i++) merged[i] = s.fmask[i] ? s.alu[i] : m_psr[i];
    if (s.ir && m_isr) nxt = m_shadow;
    else if (s.pwe)    nxt = s.pin;
    else if (s.fwe)    nxt = merged;
    else               nxt = m_psr;
    e.psr  = m_psr;
    e.isr  = m_isr;
    e.ack  = m_ack;
    e.take = model_take(s.cnd, FWD ? nxt : m_psr);
    expq.push_back(e);
    accept = s.ie && !m_isr;
    if (accept) m_shadow = nxt;
    m_ack = accept;
    if (accept) m_isr = 1'b1;
    else if (s.ir && m_isr) m_isr = 1'b0;
    m_psr = nxt;
    if (s.rst) begin
      m_psr = 5'b0; m_shadow = 5'b0; m_isr = 1'b0; m_ack = 1'b0;
    end
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("sb_psr",    psr,    e.psr);
        check("sb_inIsr",  inIsr,  e.isr);
        check("sb_intAck", intAck, e.ack);
        check("sb_take",   take,   e.take);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Driver
  initial begin
    stim_t s;

    s = idle(0); s.rst = 1'b1; step(s);
    step(idle(0));  @(negedge clk);
    check("rst_psr", psr, 5'b0); check("rst_isr", inIsr, 0);
    check("rst_ack", intAck, 0); check("rst_eq", take, 0);
    step(idle(1));  @(negedge clk); check("rst_ne", take, 1);
    step(idle(15)); @(negedge clk); check("rst_never", take, 0);

    s = idle(0); s.pwe = 1'b1; s.pin = 5'b11111; step(s);
    s = idle(0); s.fwe = 1'b1; s.fmask = 5'b00010; s.alu = 5'b0; step(s);
    step(idle(0)); @(negedge clk);
    check("mask_psr", psr, 5'b11101); check("mask_eq", take, 0);

    s = idle(14); s.pwe = 1'b1; s.pin = 5'b10000;
    s.fwe = 1'b1; s.fmask = 5'b11111; s.alu = 5'b01111; step(s);
    step(idle(14)); @(negedge clk); check("prio_psr", psr, 5'b10000);

    s = idle(14); s.pwe = 1'b1; s.pin = 5'b00110; step(s);
    s = idle(14); s.ie = 1'b1; step(s);
    step(idle(14)); @(negedge clk);
    check("ent_ack", intAck, 1); check("ent_isr", inIsr, 1); check("ent_psr", psr, 5'b00110);
    step(idle(14)); @(negedge clk); check("ent_ack_pulse", intAck, 0);
    s = idle(14); s.fwe = 1'b1; s.fmask = 5'b11111; s.alu = 5'b11001; step(s);
    s = idle(14); s.ie = 1'b1; step(s);
    step(idle(14)); @(negedge clk);
    check("isr_psr", psr, 5'b11001); check("nest_ack", intAck, 0); check("nest_isr", inIsr, 1);
    s = idle(14); s.ir = 1'b1; step(s);
    step(idle(14)); @(negedge clk);
    check("reti_psr", psr, 5'b00110); check("reti_isr", inIsr, 0);

    s = idle(0); s.pwe = 1'b1; s.pin = 5'b00000; step(s);
    step(idle(10)); @(negedge clk); check("lo_z0", take, 1);
    step(idle(11)); @(negedge clk); check("hs_z0", take, 0);
    step(idle(12)); @(negedge clk); check("lt_z0", take, 1);
    step(idle(13)); @(negedge clk); check("ge_z0", take, 0);
    s = idle(0); s.pwe = 1'b1; s.pin = 5'b00010; step(s);
    step(idle(10)); @(negedge clk); check("lo_z1", take, 0);
    step(idle(11)); @(negedge clk); check("hs_z1", take, 1);
    s = idle(0); s.pwe = 1'b1; s.pin = 5'b00001; step(s);
    step(idle(12)); @(negedge clk); check("lt_n1", take, 0);
    step(idle(13)); @(negedge clk); check("ge_n1", take, 1);

    s = idle(14); s.ie = 1'b1; s.ir = 1'b1; step(s);
    step(idle(14)); @(negedge clk);
    check("both_run_isr", inIsr, 1); check("both_run_ack", intAck, 1);
    s = idle(14); s.ie = 1'b1; s.ir = 1'b1; step(s);
    step(idle(14)); @(negedge clk);
    check("both_isr_isr", inIsr, 0); check("both_isr_ack", intAck, 0);

    s = idle(14); s.pwe = 1'b1; s.pin = 5'b10101; step(s);
    s = idle(14); s.ie = 1'b1; step(s);
    step(idle(14));
    s = idle(14); s.rst = 1'b1; step(s);
    step(idle(14)); @(negedge clk);
    check("rst_isr_psr", psr, 5'b0); check("rst_isr_isr", inIsr, 0);
    s = idle(14); s.ir = 1'b1; step(s);
    step(idle(14)); @(negedge clk); check("reti_run_psr", psr, 5'b0);

    s = idle(0); s.pwe = 1'b1; s.pin = 5'b00000; step(s);
    s = idle(0); s.fwe = 1'b1; s.fmask = 5'b00010; s.alu = 5'b00010; step(s);
    @(negedge clk); check("fwd_same", take, FWD);
    step(idle(0)); @(negedge clk); check("fwd_next", take, 1);

    for (int i = 0; i < 400; i++) begin
      s.rst   = ($urandom_range(0, 63) == 0);
      s.fwe   = $urandom_range(0, 1);
      s.fmask = 5'($urandom);
      s.alu   = 5'($urandom);
      s.pwe   = ($urandom_range(0, 3) == 0);
      s.pin   = 5'($urandom);
      s.ie    = ($urandom_range(0, 5) == 0);
      s.ir    = ($urandom_range(0, 5) == 0);
      s.cnd   = 4'($urandom);
      step(s);
    end

    repeat (2) @(negedge clk);
    check("queue_drain", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
